psum_writeback_buffer: RTL and testbench

Downstream stage of the 16x16 PE array controller. Captures the delayed accumulator stream (enable/clear/address plus the 16-lane 32-bit bottom-row results) into a local partial-sum buffer, summing across kernel slices. On command it drains the buffer through a requantizer (round, shift, optional ReLU, int8 saturate) to the output memory over a valid/ready handshake.

---
 rtl/psum_writeback_buffer.sv | 217 +++++++++++++++++++++
 tb/tb_psum_writeback_buffer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_writeback_buffer.sv
// Partial-sum writeback buffer: accumulates the PE array bottom-row stream into a
// local buffer and drains it through an int8 requantizer over a valid/ready port.
module psum_writeback_buffer #(
    parameter int ARRAY_DIM = 16,
    parameter int ACC_W     = 32,
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       acc_enable,
    input  logic                       acc_clear,
    input  logic [ADDR_W-1:0]          acc_addr,
    input  logic [ARRAY_DIM*ACC_W-1:0] pe_acc_out,
    input  logic                       drain_start,
    input  logic [ADDR_W:0]            drain_count,
    input  logic [4:0]                 shift,
    input  logic                       relu_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [ARRAY_DIM*8-1:0]     out_data,
    output logic                       busy,
    output logic                       drain_done,
    output logic                       overlap_err,
    output logic [1:0]                 dbg_state
);

    localparam int DATA_W = ARRAY_DIM * ACC_W;
    localparam int OUT_W  = ARRAY_DIM * 8;
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(128);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Output handshake: a word transfers on a rising clk edge where out_valid and
    // out_ready are both high; while out_valid is high and out_ready low, out_addr
    // and out_data hold, and out_valid never drops without a transfer.

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       fetch_q, fetch_d;
    logic [CNT_W-1:0]       accept_q, accept_d;
    logic [4:0]             shift_q, shift_d;
    logic                   relu_q, relu_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]      rd_data_q, rd_data_d;
    logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
    logic                   out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]      out_addr_q, out_addr_d;
    logic [OUT_W-1:0]       out_data_q, out_data_d;
    logic                   drain_done_q, drain_done_d;
    logic                   overlap_q, overlap_d;

    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic [DATA_W-1:0]      wr_old;
    logic [DATA_W-1:0]      wr_data;
    logic                   wr_en;
    logic [OUT_W-1:0]       q_data;

    logic                   start_ok, start_go, out_fire, out_adv, rd_adv;
    logic                   fetch_en, last_accept;
    logic [ADDR_W-1:0]      fetch_addr;

    function automatic logic [7:0] requant_lane(input logic signed [ACC_W-1:0] v,
                                                input logic [4:0] sh,
                                                input logic relu);
        logic signed [ACC_W-1:0] x;
        logic signed [ACC_W-1:0] y;
        x = v;
        // Round-half-up bias; wraps modulo 2^ACC_W on overflow.
        if (sh != 5'd0) x = x + (ACC_W'(1) << (sh - 5'd1));
        y = x >>> sh;
        if (relu && y[ACC_W-1]) y = '0;
        if (y > SAT_MAX) return 8'h7f;
        if (y < SAT_MIN) return 8'h80;
        return y[7:0];
    endfunction

    // Accumulate path: single-cycle read-modify-write, blocked while draining.
    always_comb begin
        wr_old  = mem_q[acc_addr];
        wr_data = pe_acc_out;
        for (int i = 0; i < ARRAY_DIM; i++) begin
            if (!acc_clear) begin
                wr_data[i*ACC_W +: ACC_W] = wr_old[i*ACC_W +: ACC_W] + pe_acc_out[i*ACC_W +: ACC_W];
            end
        end
        wr_en = acc_enable && (state_q != DRAIN) && (int'(acc_addr) < DEPTH);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[acc_addr] <= wr_data;
    end

    always_comb begin
        q_data = '0;
        for (int i = 0; i < ARRAY_DIM; i++) begin
            q_data[i*8 +: 8] = requant_lane(rd_data_q[i*ACC_W +: ACC_W], shift_q, relu_q);
        end
    end

    // Two-stage drain pipeline (read register, requant register), each stage
    // advancing whenever the stage after it is empty or handing its word on.
    always_comb begin
        start_ok    = (state_q == IDLE) && drain_start;
        start_go    = start_ok && (drain_count != '0);
        out_fire    = out_valid_q && out_ready;
        out_adv     = !out_valid_q || out_ready;
        rd_adv      = !rd_valid_q || out_adv;
        fetch_en    = start_go || ((state_q == DRAIN) && (fetch_q < count_q) && rd_adv);
        fetch_addr  = start_go ? '0 : fetch_q[ADDR_W-1:0];
        last_accept = (state_q == DRAIN) && out_fire && (accept_q == count_q - CNT_W'(1));

        state_d      = state_q;
        count_d      = count_q;
        shift_d      = shift_q;
        relu_d       = relu_q;
        fetch_d      = fetch_q + CNT_W'(fetch_en);
        accept_d     = accept_q + CNT_W'(out_fire);
        rd_valid_d   = rd_valid_q;
        rd_data_d    = rd_data_q;
        rd_addr_d    = rd_addr_q;
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        drain_done_d = (start_ok && (drain_count == '0)) || last_accept;
        overlap_d    = overlap_q;

        case (state_q)
            IDLE: begin
                if (start_go) begin
                    state_d   = DRAIN;
                    count_d   = drain_count;
                    shift_d   = shift;
                    relu_d    = relu_en;
                    fetch_d   = CNT_W'(1);
                    accept_d  = '0;
                    overlap_d = 1'b0;
                end
            end
            DRAIN: begin
                if (acc_enable) overlap_d = 1'b1;
                if (last_accept) state_d = FLUSH;
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rd_adv) begin
            rd_valid_d = fetch_en;
            if (fetch_en) begin
                rd_data_d = mem_q[fetch_addr];
                rd_addr_d = fetch_addr;
            end
        end
        if (out_adv) begin
            out_valid_d = rd_valid_q;
            if (rd_valid_q) begin
                out_data_d = q_data;
                out_addr_d = rd_addr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            fetch_q      <= '0;
            accept_q     <= '0;
            shift_q      <= '0;
            relu_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_addr_q    <= '0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            drain_done_q <= 1'b0;
            overlap_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            fetch_q      <= fetch_d;
            accept_q     <= accept_d;
            shift_q      <= shift_d;
            relu_q       <= relu_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_addr_q    <= rd_addr_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            drain_done_q <= drain_done_d;
            overlap_q    <= overlap_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_addr    = out_addr_q;
    assign out_data    = out_data_q;
    assign busy        = (state_q == DRAIN) || (state_q == FLUSH);
    assign drain_done  = drain_done_q;
    assign overlap_err = overlap_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_psum_writeback_buffer.sv
// Self-checking bench for psum_writeback_buffer: vector table, directed corner
// sequences and randomized accumulate/drain rounds against a lane-level model.
module tb_psum_writeback_buffer;

  localparam int LANES  = 16;
  localparam int DATA_W = 512;
  localparam int OUT_W  = 128;
  localparam int EXP_W  = 10 + OUT_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              acc_enable = 1'b0;
  logic              acc_clear = 1'b0;
  logic [9:0]        acc_addr = '0;
  logic [DATA_W-1:0] pe_acc_out = '0;
  logic              drain_start = 1'b0;
  logic [10:0]       drain_count = '0;
  logic [4:0]        shift = '0;
  logic              relu_en = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [9:0]        out_addr;
  logic [OUT_W-1:0]  out_data;
  logic              busy;
  logic              drain_done;
  logic              overlap_err;
  logic [1:0]        dbg_state;

  psum_writeback_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .acc_enable(acc_enable), .acc_clear(acc_clear), .acc_addr(acc_addr),
    .pe_acc_out(pe_acc_out),
    .drain_start(drain_start), .drain_count(drain_count), .shift(shift), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .drain_done(drain_done), .overlap_err(overlap_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] ref_mem [1024];
  logic [EXP_W-1:0]  exp_q[$];
  logic [OUT_W-1:0]  got_data [64];

  task automatic chk(input string nm, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference requantizer written directly from the arithmetic rules
  function automatic logic [7:0] m_requant(input logic [31:0] v, input int sh, input bit relu);
    longint x;
    logic [63:0] xb;
    x = longint'($signed(v));
    if (sh > 0) x = x + (longint'(1) << (sh - 1));
    xb = x;
    x = longint'($signed(xb[31:0]));
    x = x >>> sh;
    if (relu && x < 0) x = 0;
    if (x > 127) x = 127;
    if (x < -128) x = -128;
    xb = x;
    return xb[7:0];
  endfunction

  function automatic logic [DATA_W-1:0] splat(input logic [31:0] v);
    logic [DATA_W-1:0] d;
    for (int l = 0; l < LANES; l++) d[l*32 +: 32] = v;
    return d;
  endfunction

  // driver: one accumulate-stream beat, model updated lane by lane
  task automatic do_write(input int addr, input bit clr, input logic [DATA_W-1:0] d);
    logic [9:0] a;
    a = addr[9:0];
    acc_enable = 1'b1;
    acc_clear = clr;
    acc_addr = a;
    pe_acc_out = d;
    for (int l = 0; l < LANES; l++) begin
      if (clr) ref_mem[a][l*32 +: 32] = d[l*32 +: 32];
      else     ref_mem[a][l*32 +: 32] = ref_mem[a][l*32 +: 32] + d[l*32 +: 32];
    end
    @(negedge clk);
    acc_enable = 1'b0;
  endtask

  // driver + monitor for one drain; mode 0 ready high, 1 random, 2 fixed pattern
  task automatic run_drain(input int cnt, input int sh, input bit relu, input int mode, input int inj_addr);
    logic [OUT_W-1:0] w;
    logic [EXP_W-1:0] e;
    logic [6:0] pat;
    bit seen_valid, prev_stall;
    logic [9:0] prev_addr;
    logic [OUT_W-1:0] prev_data;
    int pi, idx, last_cyc, done_cnt, done_cyc, cyc, budget;
    pat = 7'b1011001;  // applied from bit 0 upward: 1,0,0,1,1,0,1
    exp_q.delete();
    for (int i = 0; i < cnt; i++) begin
      for (int l = 0; l < LANES; l++) w[l*8 +: 8] = m_requant(ref_mem[i][l*32 +: 32], sh, relu);
      exp_q.push_back({10'(i), w});
    end
    drain_start = 1'b1;
    drain_count = 11'(cnt);
    shift = 5'(sh);
    relu_en = relu;
    out_ready = (mode == 0);
    @(negedge clk);
    drain_start = 1'b0;
    seen_valid = 0; prev_stall = 0; prev_addr = '0; prev_data = '0;
    pi = 0; idx = 0; last_cyc = 0; done_cnt = 0; done_cyc = 0;
    budget = cnt * 40 + 50;
    cyc = 1;
    while (1) begin
      if (out_valid) seen_valid = 1;
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) begin
        if (seen_valid && pi < 7) begin out_ready = pat[pi]; pi++; end
        else out_ready = 1'b1;
      end
      if (inj_addr >= 0 && cyc == 1) begin
        acc_enable = 1'b1; acc_clear = 1'b1; acc_addr = inj_addr[9:0]; pe_acc_out = splat($urandom());
      end
      if (inj_addr >= 0 && cyc == 2) acc_enable = 1'b0;
      if (cyc == 1) begin
        chk("busy_after_start", EXP_W'(busy), EXP_W'(1));
        chk("valid_not_early", EXP_W'(out_valid), EXP_W'(0));
        chk("overlap_cleared", EXP_W'(overlap_err), EXP_W'(0));
      end
      if (cyc == 2) chk("valid_latency", EXP_W'(out_valid), EXP_W'(1));
      if (prev_stall) chk("stall_hold", {out_valid, out_addr, out_data}, {1'b1, prev_addr, prev_data});
      if (last_cyc > 0 && cyc == last_cyc + 1)
        chk("flush_state", {busy, out_valid}, {1'b1, 1'b0});
      if (drain_done) begin done_cnt++; done_cyc = cyc; end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_word", {out_addr, out_data}, '0);
        else begin
          e = exp_q.pop_front();
          chk("drain_word", {out_addr, out_data}, e);
          if (idx < 64) got_data[idx] = out_data;
          idx++;
          if (exp_q.size() == 0) last_cyc = cyc;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_addr = out_addr;
      prev_data = out_data;
      if (last_cyc > 0 && cyc >= last_cyc + 2) break;
      if (cyc > budget) begin
        chk("drain_timeout", EXP_W'(exp_q.size()), EXP_W'(0));
        break;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk("done_once", EXP_W'(done_cnt), EXP_W'(1));
    chk("done_timing", EXP_W'(done_cyc), EXP_W'(last_cyc + 1));
    chk("busy_end", EXP_W'(busy), EXP_W'(0));
    if (inj_addr >= 0) chk("overlap_set", EXP_W'(overlap_err), EXP_W'(1));
  endtask

  typedef struct {
    logic [31:0] val;
    int          sh;
    bit          relu;
    logic [7:0]  exp;
  } rq_vec_t;

  rq_vec_t vecs[13];

  initial begin
    vecs[0]  = '{32'h7FFF_FFFE, 1, 0, 8'h7f};
    vecs[1]  = '{-32'sd300,     1, 0, 8'h80};
    vecs[2]  = '{32'd383,       1, 0, 8'h7f};
    vecs[3]  = '{-32'sd129,     1, 0, 8'hc0};
    vecs[4]  = '{32'h7FFF_FFFE, 1, 1, 8'h7f};
    vecs[5]  = '{-32'sd300,     1, 1, 8'h00};
    vecs[6]  = '{32'd383,       1, 1, 8'h7f};
    vecs[7]  = '{-32'sd129,     1, 1, 8'h00};
    vecs[8]  = '{32'd5,         1, 0, 8'h03};
    vecs[9]  = '{-32'sd5,       1, 0, 8'hfe};
    vecs[10] = '{32'd4,         2, 0, 8'h01};
    vecs[11] = '{32'd100,       0, 0, 8'h64};
    vecs[12] = '{-32'sd200,     0, 0, 8'h80};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {out_valid, out_addr, out_data, busy, drain_done, overlap_err},
        {1'b0, 10'd0, 128'd0, 1'b0, 1'b0, 1'b0});
    chk("reset_outputs_hold", {out_valid, busy, drain_done}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 32; a++) do_write(a, 1'b1, splat(32'(a)));

    // requantizer vector table
    for (int i = 0; i < 13; i++) begin
      do_write(0, 1'b1, splat(vecs[i].val));
      run_drain(1, vecs[i].sh, vecs[i].relu, 0, -1);
      chk($sformatf("requant_vec%0d", i), EXP_W'(got_data[0][7:0]), EXP_W'(vecs[i].exp));
    end

    // clear then accumulate
    do_write(5, 1'b1, splat(32'd10));
    for (int k = 0; k < 3; k++) do_write(5, 1'b0, splat(-32'sd4));
    run_drain(6, 0, 0, 0, -1);
    chk("clear_then_acc", EXP_W'(got_data[5]), EXP_W'({16{8'hfe}}));

    // same-address back-to-back
    do_write(0, 1'b1, splat(32'd1));
    do_write(0, 1'b0, splat(32'd1));
    do_write(0, 1'b0, splat(32'd1));
    run_drain(1, 0, 0, 0, -1);
    chk("back_to_back", EXP_W'(got_data[0]), EXP_W'({16{8'h03}}));

    // backpressure pattern
    run_drain(4, 0, 0, 2, -1);

    // overlap: write during drain is dropped, next drain shows old contents
    run_drain(4, 0, 0, 0, 3);
    run_drain(4, 0, 0, 0, -1);

    // zero-length drain
    drain_start = 1'b1; drain_count = '0;
    @(negedge clk);
    drain_start = 1'b0;
    chk("zero_drain_done", {drain_done, busy}, {1'b1, 1'b0});
    @(negedge clk);
    chk("zero_drain_pulse", EXP_W'(drain_done), EXP_W'(0));

    // reset mid-drain
    drain_start = 1'b1; drain_count = 11'd8; out_ready = 1'b0;
    @(negedge clk);
    drain_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_valid", EXP_W'(out_valid), EXP_W'(1));
    rst_n = 1'b0;
    #1;
    chk("reset_mid_drain", {out_valid, busy, drain_done, out_addr, out_data}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int dcnt;
      dcnt = 0;
      repeat (6) begin @(negedge clk); if (drain_done || busy) dcnt++; end
      chk("no_done_after_reset", EXP_W'(dcnt), EXP_W'(0));
    end

    // randomized rounds
    for (int r = 0; r < 12; r++) begin
      int nw;
      nw = $urandom_range(4, 20);
      for (int k = 0; k < nw; k++) begin
        logic [DATA_W-1:0] d;
        for (int l = 0; l < LANES; l++)
          d[l*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'($urandom()) : 32'($signed($urandom_range(0, 4000)) - 2000);
        do_write($urandom_range(0, 31), 1'($urandom_range(0, 1)), d);
      end
      run_drain($urandom_range(1, 16), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                $urandom_range(0, 1), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
